// File: rtl/debouncer_pkg.sv
// -----------------------------------------------------------------------------
// debouncer_pkg
// Shared constants and types for the multi-channel button conditioner.
//   CLK_HZ        : system clock frequency the default timings are derived from
//   DEB_10MS      : default debounce stability window (10 ms)
//   HOLD_1S       : default press-to-long-press time (1 s)
//   REPEAT_200MS  : default auto-repeat period (200 ms)
//   hold_state_e  : per-channel hold FSM state encoding
// -----------------------------------------------------------------------------
package debouncer_pkg;

    localparam int CLK_HZ       = 50_000_000;
    localparam int DEB_10MS     = CLK_HZ / 100;
    localparam int HOLD_1S      = CLK_HZ;
    localparam int REPEAT_200MS = CLK_HZ / 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } hold_state_e;

endpackage

// File: rtl/debouncer_multi_if.sv
// -----------------------------------------------------------------------------
// debouncer_multi_if
// Bundles the raw button pins and the conditioned per-channel outputs.
//   botao_i      : raw asynchronous button pins, bit i = channel i
//   nivel_o      : debounced level (1 = pressed)
//   press_o      : one-cycle strobe on debounced press
//   release_o    : one-cycle strobe on debounced release
//   long_press_o : one-cycle strobe when a hold reaches the long-press time
//   repeat_o     : one-cycle strobe at each auto-repeat period while held
//   state_o      : hold FSM state per channel, 2 bits each (debug)
//
// Signalling: there is no valid/ready flow control. Every *_o strobe is a
// registered single-cycle pulse that the consumer must sample on the clock
// edge it is high; nivel_o is a continuous level. No back-pressure exists.
// -----------------------------------------------------------------------------
interface debouncer_multi_if #(
    parameter int N_CANAIS = 4
);
    logic [N_CANAIS-1:0]   botao_i;
    logic [N_CANAIS-1:0]   nivel_o;
    logic [N_CANAIS-1:0]   press_o;
    logic [N_CANAIS-1:0]   release_o;
    logic [N_CANAIS-1:0]   long_press_o;
    logic [N_CANAIS-1:0]   repeat_o;
    logic [2*N_CANAIS-1:0] state_o;

    // Producer of the pins / consumer of the conditioned outputs.
    modport master (
        output botao_i,
        input  nivel_o,
        input  press_o,
        input  release_o,
        input  long_press_o,
        input  repeat_o,
        input  state_o
    );

    // The conditioner itself.
    modport slave (
        input  botao_i,
        output nivel_o,
        output press_o,
        output release_o,
        output long_press_o,
        output repeat_o,
        output state_o
    );
endinterface

// File: rtl/debouncer_canal.sv
// -----------------------------------------------------------------------------
// debouncer_canal
// One button channel: optional inversion, two-flop synchroniser, stability
// timer debounce, press/release edge pulses, debounced level, long-press
// detection and auto-repeat while held. All outputs are registered.
//   clock, reset   : system clock, asynchronous active-high reset
//   botao_i        : raw asynchronous pin
//   nivel_o        : debounced level
//   press_o        : pulse on debounced press
//   release_o      : pulse on debounced release
//   long_press_o   : pulse HOLD_CYCLES cycles after the press pulse
//   repeat_o       : pulse every REPEAT_CYCLES after long press while held
//   state_o        : hold FSM state (debug)
// -----------------------------------------------------------------------------
module debouncer_canal
    import debouncer_pkg::*;
#(
    parameter int LIMIT_TIMER   = DEB_10MS,
    parameter int CNT_W         = 20,
    parameter int HOLD_CYCLES   = HOLD_1S,
    parameter int REPEAT_CYCLES = REPEAT_200MS,
    parameter int HOLD_W        = 26,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       botao_i,
    output logic       nivel_o,
    output logic       press_o,
    output logic       release_o,
    output logic       long_press_o,
    output logic       repeat_o,
    output logic [1:0] state_o
);

    localparam logic             INV      = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(LIMIT_TIMER);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] REP_LIM  = HOLD_W'(REPEAT_CYCLES);
    localparam logic [HOLD_W-1:0] HCNT_ONE = HOLD_W'(1);

    logic              sync0_q, sync1_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stable_q, stable_d;
    logic              prev_q;
    logic              nivel_q, press_q, release_q;
    hold_state_e       state_q, state_d;
    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic              long_q, long_d;
    logic              rep_q, rep_d;

    logic              x;
    logic              rise;

    // Inversion before the synchroniser keeps the reset value 0 meaning
    // "released" regardless of pin polarity.
    assign x    = botao_i ^ INV;
    assign rise = stable_q & ~prev_q;

    // Debounce: the stable level only follows the synchronised input after
    // LIMIT_TIMER+1 consecutive mismatching cycles; any agreeing cycle
    // restarts the window.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync1_q != stable_q) begin
            if (cnt_q >= LIMIT) begin
                stable_d = sync1_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Hold FSM. The FSM enters HOLD on the same edge that registers the
    // press pulse, so hcnt == HOLD_CYCLES lands exactly HOLD_CYCLES edges
    // after the press pulse. A released stable level overrides everything,
    // which suppresses any long/repeat pulse coinciding with or following
    // the release pulse.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        if ((HOLD_CYCLES == 0) || !stable_q) begin
            state_d = IDLE;
            hcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HOLD;
                        hcnt_d  = HCNT_ONE;
                    end
                end
                HOLD: begin
                    // hcnt == 0 while in HOLD marks the parked state after a
                    // long press with repeat disabled; the count stays frozen.
                    if (hcnt_q == '0) begin
                        hcnt_d = '0;
                    end else if (hcnt_q == HOLD_LIM) begin
                        long_d = 1'b1;
                        if (REPEAT_CYCLES > 0) begin
                            state_d = REPEAT;
                            hcnt_d  = HCNT_ONE;
                        end else begin
                            hcnt_d = '0;
                        end
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (hcnt_q == REP_LIM) begin
                        rep_d  = 1'b1;
                        hcnt_d = HCNT_ONE;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync0_q   <= 1'b0;
            sync1_q   <= 1'b0;
            cnt_q     <= '0;
            stable_q  <= 1'b0;
            prev_q    <= 1'b0;
            nivel_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            state_q   <= IDLE;
            hcnt_q    <= '0;
            long_q    <= 1'b0;
            rep_q     <= 1'b0;
        end else begin
            sync0_q   <= x;
            sync1_q   <= sync0_q;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            prev_q    <= stable_q;
            nivel_q   <= stable_q;
            press_q   <= rise;
            release_q <= ~stable_q & prev_q;
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            long_q    <= long_d;
            rep_q     <= rep_d;
        end
    end

    assign nivel_o      = nivel_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;
    assign repeat_o     = rep_q;
    assign state_o      = state_q;

endmodule

// File: rtl/debouncer_multi.sv
// -----------------------------------------------------------------------------
// debouncer_multi
// N-channel button conditioner. Each channel is an independent
// debouncer_canal; no state is shared between channels.
//   clock : system clock (50 MHz nominal)
//   reset : asynchronous active-high reset
//   bus   : debouncer_multi_if.slave -- raw pins in, conditioned
//           level/pulses and per-channel hold FSM state out
// -----------------------------------------------------------------------------
module debouncer_multi
    import debouncer_pkg::*;
#(
    parameter int N_CANAIS      = 4,
    parameter int LIMIT_TIMER   = DEB_10MS,
    parameter int CNT_W         = 20,
    parameter int HOLD_CYCLES   = HOLD_1S,
    parameter int REPEAT_CYCLES = REPEAT_200MS,
    parameter int HOLD_W        = 26,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic              clock,
    input  logic              reset,
    debouncer_multi_if.slave  bus
);

    logic [N_CANAIS-1:0]   nivel_w;
    logic [N_CANAIS-1:0]   press_w;
    logic [N_CANAIS-1:0]   release_w;
    logic [N_CANAIS-1:0]   long_w;
    logic [N_CANAIS-1:0]   rep_w;
    logic [2*N_CANAIS-1:0] state_w;

    for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
        debouncer_canal #(
            .LIMIT_TIMER   (LIMIT_TIMER),
            .CNT_W         (CNT_W),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .HOLD_W        (HOLD_W),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_canal (
            .clock        (clock),
            .reset        (reset),
            .botao_i      (bus.botao_i[i]),
            .nivel_o      (nivel_w[i]),
            .press_o      (press_w[i]),
            .release_o    (release_w[i]),
            .long_press_o (long_w[i]),
            .repeat_o     (rep_w[i]),
            .state_o      (state_w[2*i +: 2])
        );
    end

    assign bus.nivel_o      = nivel_w;
    assign bus.press_o      = press_w;
    assign bus.release_o    = release_w;
    assign bus.long_press_o = long_w;
    assign bus.repeat_o     = rep_w;
    assign bus.state_o      = state_w;

endmodule

// File: tb/tb_debouncer_multi.sv
// -----------------------------------------------------------------------------
// tb_debouncer_multi
// Two conditioners share one stimulus: dut0 (active-high pins) sees botao,
// dut1 (active-low pins) sees ~botao, so both must produce identical outputs.
// A reference model derives expected pulses from the raw pin history; the
// monitor pops them on the falling edge and compares every output bit.
// -----------------------------------------------------------------------------
module tb_debouncer_multi;

    localparam int N     = 4;
    localparam int LIMIT = 5;
    localparam int HOLDC = 20;
    localparam int REPC  = 8;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;
    localparam int K_REP   = 3;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [N-1:0] botao = '0;

    debouncer_multi_if #(.N_CANAIS(N)) bus0 ();
    debouncer_multi_if #(.N_CANAIS(N)) bus1 ();

    assign bus0.botao_i = botao;
    assign bus1.botao_i = ~botao;

    debouncer_multi #(
        .N_CANAIS(N), .LIMIT_TIMER(LIMIT), .CNT_W(8), .HOLD_CYCLES(HOLDC),
        .REPEAT_CYCLES(REPC), .HOLD_W(8), .ACTIVE_LOW(0)
    ) dut0 (.clock(clock), .reset(reset), .bus(bus0));

    debouncer_multi #(
        .N_CANAIS(N), .LIMIT_TIMER(LIMIT), .CNT_W(8), .HOLD_CYCLES(HOLDC),
        .REPEAT_CYCLES(REPC), .HOLD_W(8), .ACTIVE_LOW(1)
    ) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [19:0] exp_q[$];     // {edge[15:0], channel[1:0], kind[1:0]}
    int edge_cnt = 0;          // rising edges since reset release
    logic [N-1:0] exp_nivel = '0;
    int pulse_cnt[4][N];       // dut0 pulses seen, by kind and channel

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, edge_cnt);
        end
    endtask

    // ---------------- reference model ----------------
    // Stable level follows the pin once the pin (seen two edges late through
    // the synchroniser) has disagreed with it for LIMIT+1 edges in a row.
    // Pulses: press/release one edge after the stable level changes; long
    // press HOLDC edges after the press pulse; repeats every REPC edges
    // after that, for as long as the stable level stays high.
    logic [N-1:0] m_st = '0, m_st_old = '0, m_r1 = '0, m_r2 = '0;
    int m_run[N];
    int m_rise[N];

    task automatic model_step();
        logic [15:0] e16;
        logic nst;
        int el;
        e16 = edge_cnt[15:0];
        for (int ch = 0; ch < N; ch++) begin
            logic [1:0] c2;
            c2 = ch[1:0];
            if (m_st[ch] && !m_st_old[ch]) exp_q.push_back({e16, c2, 2'd0});
            if (!m_st[ch] && m_st_old[ch]) exp_q.push_back({e16, c2, 2'd1});
            if (m_st[ch]) begin
                el = edge_cnt - (m_rise[ch] + 1);
                if (el == HOLDC) exp_q.push_back({e16, c2, 2'd2});
                else if (el > HOLDC && ((el - HOLDC) % REPC) == 0)
                    exp_q.push_back({e16, c2, 2'd3});
            end
            exp_nivel[ch] = m_st[ch];
            nst = m_st[ch];
            if (m_r2[ch] != m_st[ch]) begin
                m_run[ch]++;
                if (m_run[ch] == LIMIT + 1) begin
                    nst = m_r2[ch];
                    m_run[ch] = 0;
                    if (nst) m_rise[ch] = edge_cnt;
                end
            end else begin
                m_run[ch] = 0;
            end
            m_st_old[ch] = m_st[ch];
            m_st[ch] = nst;
            m_r2[ch] = m_r1[ch];
            m_r1[ch] = botao[ch];
        end
        edge_cnt++;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                m_st = '0; m_st_old = '0; m_r1 = '0; m_r2 = '0;
                for (int ch = 0; ch < N; ch++) begin
                    m_run[ch] = 0;
                    m_rise[ch] = 0;
                end
                exp_nivel = '0;
                exp_q.delete();
                edge_cnt = 0;
            end else begin
                model_step();
            end
        end
    end

    // ---------------- monitor ----------------
    function automatic logic pick(input int k, input logic [N-1:0] p, input logic [N-1:0] r,
                                  input logic [N-1:0] l, input logic [N-1:0] rp, input int ch);
        case (k)
            K_PRESS: return p[ch];
            K_REL:   return r[ch];
            K_LONG:  return l[ch];
            default: return rp[ch];
        endcase
    endfunction

    initial begin
        string kname[4];
        kname[0] = "press"; kname[1] = "release"; kname[2] = "long_press"; kname[3] = "repeat";
        forever begin
            @(negedge clock);
            if (!reset && edge_cnt > 0) begin
                int cur;
                logic [15:0] c16;
                cur = edge_cnt - 1;
                c16 = cur[15:0];
                for (int ch = 0; ch < N; ch++) begin
                    for (int k = 0; k < 4; k++) begin
                        logic exp_b, g0, g1;
                        logic [1:0] c2, k2;
                        c2 = ch[1:0];
                        k2 = k[1:0];
                        exp_b = (exp_q.size() > 0) && (exp_q[0] == {c16, c2, k2});
                        if (exp_b) void'(exp_q.pop_front());
                        g0 = pick(k, bus0.press_o, bus0.release_o, bus0.long_press_o, bus0.repeat_o, ch);
                        g1 = pick(k, bus1.press_o, bus1.release_o, bus1.long_press_o, bus1.repeat_o, ch);
                        if (g0 === 1'b1) pulse_cnt[k][ch]++;
                        check($sformatf("dut0_%s_ch%0d", kname[k], ch), {31'd0, g0}, {31'd0, exp_b});
                        check($sformatf("dut1_%s_ch%0d", kname[k], ch), {31'd0, g1}, {31'd0, exp_b});
                    end
                    check($sformatf("dut0_nivel_ch%0d", ch), {31'd0, bus0.nivel_o[ch]}, {31'd0, exp_nivel[ch]});
                    check($sformatf("dut1_nivel_ch%0d", ch), {31'd0, bus1.nivel_o[ch]}, {31'd0, exp_nivel[ch]});
                end
                while (exp_q.size() > 0 && exp_q[0][19:4] <= c16) begin
                    check("stale_expected_pulse", {12'd0, exp_q[0]}, 32'd0);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 4; k++)
            for (int ch = 0; ch < N; ch++)
                pulse_cnt[k][ch] = 0;
    endtask

    function automatic logic [31:0] all_outs();
        return {bus0.nivel_o, bus0.press_o, bus0.release_o, bus0.long_press_o,
                bus1.nivel_o, bus1.press_o, bus1.release_o, bus1.long_press_o};
    endfunction

    // Waits (bounded) for a pulse on dut0 of the given kind and channel;
    // returns the edge index it appeared on, or -1 on timeout.
    task automatic wait_pulse(input int k, input int ch, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (pick(k, bus0.press_o, bus0.release_o, bus0.long_press_o, bus0.repeat_o, ch) === 1'b1) begin
                at = edge_cnt - 1;
                break;
            end
        end
    endtask

    task automatic drive_bounce_ch1();
        int lvl[4];
        int len[4];
        lvl = '{1, 0, 1, 0};
        len = '{4, 2, 3, 30};
        for (int s = 0; s < 4; s++) begin
            botao[1] = lvl[s][0];
            wait_cycles(len[s]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k, at, p_at;
        int dur[N];

        // Reset with all pins idle (dut1 pins therefore held at 1).
        reset = 1'b1;
        botao = '0;
        wait_cycles(3);
        check("reset_outputs_zero", all_outs(), 32'd0);
        check("reset_state_zero", {16'd0, bus0.state_o, bus1.state_o}, 32'd0);
        reset = 1'b0;
        wait_cycles(20);
        check("idle_after_reset", all_outs(), 32'd0);

        // Clean press on channel 0.
        k = edge_cnt;
        botao[0] = 1'b1;
        wait_pulse(K_PRESS, 0, 20, at);
        check("t1_press_latency", at, k + 8);
        check("t1_nivel_high", {31'd0, bus0.nivel_o[0]}, 32'd1);

        // Bounce on channel 1 shorter than the stability window.
        clear_counts();
        drive_bounce_ch1();
        check("t2_bounce_no_pulses", pulse_cnt[0][1] + pulse_cnt[1][1] + pulse_cnt[2][1] + pulse_cnt[3][1], 0);
        check("t2_bounce_nivel", {31'd0, bus0.nivel_o[1]}, 32'd0);
        botao[0] = 1'b0;
        wait_cycles(20);

        // Long hold on channel 2: one long press and five repeats.
        clear_counts();
        botao[2] = 1'b1;
        wait_cycles(64);
        botao[2] = 1'b0;
        wait_cycles(40);
        check("t3_press_cnt", pulse_cnt[K_PRESS][2], 1);
        check("t3_long_cnt", pulse_cnt[K_LONG][2], 1);
        check("t3_repeat_cnt", pulse_cnt[K_REP][2], 5);
        check("t3_release_cnt", pulse_cnt[K_REL][2], 1);

        // Release on channel 3 lands on the long-press edge.
        clear_counts();
        botao[3] = 1'b1;
        wait_cycles(20);
        botao[3] = 1'b0;
        wait_cycles(40);
        check("t4_release_cnt", pulse_cnt[K_REL][3], 1);
        check("t4_long_cnt", pulse_cnt[K_LONG][3], 0);
        check("t4_repeat_cnt", pulse_cnt[K_REP][3], 0);

        // Asynchronous reset while ch0 repeats and ch1 is mid-debounce.
        botao[0] = 1'b1;
        wait_cycles(40);
        botao[1] = 1'b1;
        wait_cycles(3);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_reset_outputs", all_outs(), 32'd0);
        check("t5_async_reset_state", {16'd0, bus0.state_o, bus1.state_o}, 32'd0);
        wait_cycles(3);
        reset = 1'b0;
        k = edge_cnt;
        wait_pulse(K_PRESS, 0, 20, p_at);
        check("t5_press_after_reset", p_at, k + 8);
        wait_pulse(K_LONG, 0, 30, at);
        check("t5_long_after_reset", at, p_at + 20);
        botao = '0;
        wait_cycles(40);

        // Randomised mix of bounces, short presses and long holds.
        for (int ch = 0; ch < N; ch++) dur[ch] = 0;
        repeat (1500) begin
            @(negedge clock);
            for (int ch = 0; ch < N; ch++) begin
                if (dur[ch] == 0) begin
                    botao[ch] = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 2))
                        0: dur[ch] = $urandom_range(1, 6);
                        1: dur[ch] = $urandom_range(6, 14);
                        default: dur[ch] = $urandom_range(20, 60);
                    endcase
                end else begin
                    dur[ch]--;
                end
            end
        end
        botao = '0;
        wait_cycles(40);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
